// File: rtl/fib_pkg.sv
// fib_pkg: shared widths and term type for the Fibonacci stream consumer.
package fib_pkg;
    localparam int FIB_WIDTH      = 6;
    localparam int FIB_FIFO_DEPTH = 8;
    typedef logic [FIB_WIDTH-1:0] term_t;
endpackage

// File: rtl/fib_fifo.sv
// fib_fifo: synchronous FIFO with flush; a push during flush lands in slot 0 of the emptied buffer.
module fib_fifo
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int DEPTH = FIB_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp, wa;

    assign wa    = flush ? '0 : wp;
    assign full  = level == CNT_W'(DEPTH);
    assign empty = level == '0;
    assign rdata = empty ? '0 : mem[rp];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (flush) begin
            wp    <= push ? AW'(1) : '0;
            rp    <= '0;
            level <= push ? CNT_W'(1) : '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            level <= level + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) mem[wa] <= wdata;
    end
endmodule

// File: rtl/fib_collector.sv
// fib_collector: checks a Fibonacci term stream against its recurrence and buffers the terms
// for a valid/ready reader, with sticky overflow/mismatch flags.
module fib_collector
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int DEPTH = FIB_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             gen_start,
    input  logic             fn_valid,
    input  logic [WIDTH-1:0] fn,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic             overflow,
    output logic             mismatch,
    output logic [7:0]       term_idx
);
    logic [WIDTH-1:0] prev1, prev2;
    logic [WIDTH:0]   sum;
    logic             push, pop;

    // gen_start empties the FIFO first, so a simultaneous term is always accepted
    assign push     = fn_valid & (gen_start | ~full);
    assign pop      = rd_valid & rd_ready & ~gen_start;
    assign rd_valid = ~empty;
    assign sum      = {1'b0, prev1} + {1'b0, prev2};

    fib_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (gen_start),
        .push  (push),
        .pop   (pop),
        .wdata (fn),
        .rdata (rd_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev1    <= '0;
            prev2    <= '0;
            term_idx <= '0;
            overflow <= 1'b0;
            mismatch <= 1'b0;
            drop     <= 1'b0;
        end else if (gen_start) begin
            prev1    <= fn_valid ? fn : '0;
            prev2    <= '0;
            term_idx <= fn_valid ? 8'd1 : 8'd0;
            overflow <= 1'b0;
            mismatch <= 1'b0;
            drop     <= 1'b0;
        end else begin
            drop <= fn_valid & full;
            if (fn_valid) begin
                if (term_idx != 8'd255) term_idx <= term_idx + 8'd1;
                if (term_idx >= 8'd2) begin
                    overflow <= overflow | sum[WIDTH];
                    mismatch <= mismatch | (fn != sum[WIDTH-1:0]);
                end
                if (term_idx != 8'd0) prev2 <= prev1;
                prev1 <= fn;
            end
        end
    end
endmodule

// File: tb/tb_fib_collector.sv
// tb_fib_collector: directed stimulus against a queue-based model checked every cycle,
// plus literal expectations from hand calculation.
module tb_fib_collector;
    localparam int W = 6;
    localparam int D = 8;
    localparam int C = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         gen_start = 1'b0;
    logic         fn_valid = 1'b0;
    logic [W-1:0] fn = '0;
    logic         rd_ready = 1'b0;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic [C-1:0] level;
    logic         full, empty, drop, overflow, mismatch;
    logic [7:0]   term_idx;

    always #5 clock = ~clock;

    fib_collector #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clock     (clock),
        .reset     (reset),
        .gen_start (gen_start),
        .fn_valid  (fn_valid),
        .fn        (fn),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop      (drop),
        .overflow  (overflow),
        .mismatch  (mismatch),
        .term_idx  (term_idx)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 0;

    int q[$];
    int hist[$];
    int m_idx = 0;
    bit m_ovf = 0, m_mis = 0, m_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take_term(input int f);
        if (hist.size() >= 2) begin
            int s;
            s = hist[hist.size()-1] + hist[hist.size()-2];
            if (s >= (1 << W)) m_ovf = 1;
            if (f != s % (1 << W)) m_mis = 1;
        end
        hist.push_back(f);
        if (m_idx < 255) m_idx++;
    endtask

    task automatic clear_model();
        q.delete();
        hist.delete();
        m_idx = 0;
        m_ovf = 0;
        m_mis = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input bit r, input bit g, input bit v, input int f, input bit rr);
        bit was_full;
        if (!r) begin
            clear_model();
        end else if (g) begin
            clear_model();
            if (v) begin
                take_term(f);
                q.push_back(f);
            end
        end else begin
            was_full = q.size() == D;
            m_drop = v && was_full;
            if (rr && q.size() > 0) void'(q.pop_front());
            if (v && !was_full) q.push_back(f);
            if (v) take_term(f);
        end
    endtask

    task automatic cyc(input bit r, input bit g, input bit v, input int f, input bit rr);
        reset = r;
        gen_start = g;
        fn_valid = v;
        fn = W'(f);
        rd_ready = rr;
        @(posedge clock);
        model_step(r, g, v, f, rr);
        #1;
    endtask

    always @(negedge clock) begin
        if (run) begin
            chk("rd_valid", int'(rd_valid), int'(q.size() > 0));
            chk("rd_data", int'(rd_data), q.size() > 0 ? q[0] : 0);
            chk("level", int'(level), q.size());
            chk("full", int'(full), int'(q.size() == D));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("drop", int'(drop), int'(m_drop));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("mismatch", int'(mismatch), int'(m_mis));
            chk("term_idx", int'(term_idx), m_idx);
        end
    end

    int seq1[11] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25};
    int drops;
    int a, b, t;

    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        run = 1;
        chk("reset_empty", int'(empty), 1);
        chk("reset_rd_data", int'(rd_data), 0);

        // 1: streaming with immediate reads, wrap at index 10
        for (int i = 0; i < 11; i++) begin
            cyc(1, 0, 1, seq1[i], 1);
            chk("t1_rd_data", int'(rd_data), seq1[i]);
            if (i == 9) chk("t1_ovf_before", int'(overflow), 0);
        end
        chk("t1_overflow", int'(overflow), 1);
        chk("t1_mismatch", int'(mismatch), 0);
        chk("t1_term_idx", int'(term_idx), 11);
        cyc(1, 0, 0, 0, 1);

        // 2: fill past capacity, then drain
        cyc(1, 1, 0, 0, 0);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, seq1[i], 0);
            if (drop) drops++;
        end
        chk("t2_level", int'(level), 8);
        chk("t2_full", int'(full), 1);
        chk("t2_drops", drops, 2);
        cyc(1, 0, 0, 0, 0);
        chk("t2_drop_clear", int'(drop), 0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_read", int'(rd_data), seq1[i]);
            cyc(1, 0, 0, 0, 1);
        end
        chk("t2_empty", int'(empty), 1);

        // 3: recurrence violation, then reseed clears
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 2, 0);
        cyc(1, 0, 1, 4, 0);
        chk("t3_mismatch", int'(mismatch), 1);
        chk("t3_overflow", int'(overflow), 0);
        cyc(1, 1, 0, 0, 0);
        chk("t3_mis_clr", int'(mismatch), 0);
        chk("t3_level", int'(level), 0);
        chk("t3_term_idx", int'(term_idx), 0);

        // 4: reseed with a term and a read request in the same cycle
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 2, 0);
        chk("t4_level3", int'(level), 3);
        cyc(1, 1, 1, 7, 1);
        chk("t4_level", int'(level), 1);
        chk("t4_rd_data", int'(rd_data), 7);
        chk("t4_term_idx", int'(term_idx), 1);

        // 5: reset mid-stream drops the concurrent term
        cyc(1, 0, 1, 11, 0);
        cyc(1, 0, 1, 18, 0);
        cyc(0, 0, 1, 29, 0);
        chk("t5_level", int'(level), 0);
        chk("t5_rd_valid", int'(rd_valid), 0);
        chk("t5_term_idx", int'(term_idx), 0);
        chk("t5_full", int'(full), 0);
        cyc(1, 0, 0, 0, 0);
        chk("t5_not_stored", int'(empty), 1);

        // 6: steady half-full push+pop across pointer wrap
        cyc(1, 1, 0, 0, 0);
        a = 1;
        b = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1, a, 0);
            t = (a + b) % 64;
            a = b;
            b = t;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, a, 1);
            t = (a + b) % 64;
            a = b;
            b = t;
            chk("t6_level", int'(level), 4);
            chk("t6_drop", int'(drop), 0);
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
        chk("t6_empty", int'(empty), 1);

        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fib_collector.md
Name: fib_collector

Overview:
- Downstream consumer of the Fibonacci generator's `fn` output stream.
- Checks every valid term against the recurrence: fn == prev1 + prev2 (mod 2^WIDTH).
- Flags arithmetic overflow (wrap-around) and recurrence mismatches with sticky flags.
- Buffers terms in a small FIFO that a reader drains through a valid/ready handshake.

Parameters:
- WIDTH, 6: term width; matches the generator's `fn` width.
- DEPTH, 8: FIFO entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1: width of the `level` output.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-low reset.
- gen_start  in  1  generator-reseed indicator, high for one cycle. Clears checker history, flags, term index and FIFO contents.
- fn_valid  in  1  `fn` carries a new term this cycle.
- fn  in  WIDTH  term from the generator.
- rd_ready  in  1  reader accepts the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  WIDTH  head entry; 0 when empty.
- level  out  CNT_W  number of stored entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- drop  out  1  one-cycle pulse: a valid term was discarded because the FIFO was full.
- overflow  out  1  sticky: some checked term had a true sum >= 2^WIDTH.
- mismatch  out  1  sticky: some checked term violated the recurrence.
- term_idx  out  8  valid terms seen since the last start; saturates at 255.

Behaviour:
- Reset (reset == 0 at a clock edge) clears:
  - all pointers, `level`, `prev1`, `prev2`, `term_idx`, `overflow`, `mismatch`, `drop`;
  - giving `rd_valid`=0, `rd_data`=0, `empty`=1, `full`=0.
- Priority: reset > gen_start > normal operation.
- `gen_start`=1: same clearing as reset, except the FIFO flush leaves memory contents undefined. If `fn_valid` is also 1 that cycle, the term is taken as index 0 after the clear: pushed into the empty FIFO, stored as `prev1`, and `term_idx` becomes 1. Any `rd_ready` that cycle is ignored (no pop).
- Push:
  - occurs when `fn_valid`=1 and `full`=0 as registered at the start of the cycle;
  - there is no same-cycle push-through when full, even with a simultaneous pop;
  - when `fn_valid`=1 and `full`=1, the term is not stored and `drop`=1 for the next cycle only.
- Pop: occurs when `rd_valid`=1 and `rd_ready`=1; `rd_ready` while empty has no effect.
- Simultaneous push and pop leave `level` unchanged.
- Latency: a pushed term appears on `rd_data` with `rd_valid`=1 on the cycle after the push, if the FIFO was empty.
- `rd_data` is driven combinationally from the head entry, and forced to 0 when empty.
- Pointers wrap modulo DEPTH; `level` is a separate counter of width CNT_W.
- Checking runs on every `fn_valid` term, independent of FIFO acceptance:
  - idx = `term_idx` before the update.
  - idx 0: prev1 <= fn.
  - idx 1: prev2 <= prev1; prev1 <= fn.
  - idx >= 2:
    - sum = prev1 + prev2, computed at WIDTH+1 bits;
    - if sum[WIDTH]=1, set `overflow`;
    - if fn != sum[WIDTH-1:0], set `mismatch`;
    - then shift: prev2 <= prev1; prev1 <= fn.
  - Flags update on the clock edge that samples the term and stay set until reset or `gen_start`.
- `term_idx` increments per valid term and holds at 255.

Decomposition:
- Package `fib_pkg`:
  - FIB_WIDTH=6 and FIB_FIFO_DEPTH=8 constants;
  - a term type of FIB_WIDTH bits.
- One sub-module, `fib_fifo`: synchronous FIFO with push/pop/flush, `level`, `full`, `empty`, and the head-data output.
- The checker, `term_idx` and sticky flags live in the top level.

Test Plan:
1. Reset, then drive seeds 1,1 and the 6-bit sequence 1,1,2,3,5,8,13,21,34,55,25 on consecutive cycles with `rd_ready`=1 -> `rd_data` matches each term one cycle later; `overflow` rises after the term 25 (index 10; true sum 89); `mismatch`=0; `term_idx`=11.
2. Hold `rd_ready`=0 and push 10 valid terms -> `level`=8, `full`=1, `drop` pulses twice. Then assert `rd_ready` -> reads 1,1,2,3,5,8,13,21 and `empty`=1.
3. Feed 1,1,2,4 -> `mismatch`=1 after the 4; `overflow`=0. Then pulse `gen_start` -> both flags 0, `level`=0, `term_idx`=0.
4. Pulse `gen_start` together with `fn_valid` (`fn`=7) and `rd_ready`=1 while FIFO holds 3 entries -> next cycle `level`=1, `rd_data`=7, `term_idx`=1.
5. Drive reset=0 mid-stream for one cycle with `fn_valid`=1 -> all outputs at reset values and the term is not stored.
6. Keep the FIFO half-full with continuous simultaneous push and pop for 20 cycles -> `level` constant, data in order across pointer wrap, no `drop`.
